float_alu_arbiter: RTL

- Shares one float_alu instance between two independent requesters (r0, r1) using valid/ready handshakes.
- Round-robin arbitration; exactly one operation in flight at a time.
- Sequences the ALU start/valid_out/ready_in handshake and routes result and flags back to the requester that issued the operation.
- A watchdog aborts operations that never complete.

---
 rtl/float_alu_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/float_alu_arbiter.sv
// Round-robin arbiter sharing one float_alu between two valid/ready requesters.
// One operation in flight at a time; a watchdog aborts operations the ALU never finishes.
module float_alu_arbiter #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req_valid,
    output logic              r0_req_ready,
    input  logic [DATA_W-1:0] r0_op_a,
    input  logic [DATA_W-1:0] r0_op_b,
    input  logic [2:0]        r0_op_code,
    input  logic              r0_round_mode,
    input  logic              r0_mode_fp,
    output logic              r0_resp_valid,
    input  logic              r0_resp_ready,
    output logic [DATA_W-1:0] r0_result,
    output logic [4:0]        r0_flags,
    output logic              r0_resp_err,
    input  logic              r1_req_valid,
    output logic              r1_req_ready,
    input  logic [DATA_W-1:0] r1_op_a,
    input  logic [DATA_W-1:0] r1_op_b,
    input  logic [2:0]        r1_op_code,
    input  logic              r1_round_mode,
    input  logic              r1_mode_fp,
    output logic              r1_resp_valid,
    input  logic              r1_resp_ready,
    output logic [DATA_W-1:0] r1_result,
    output logic [4:0]        r1_flags,
    output logic              r1_resp_err,
    output logic [DATA_W-1:0] alu_op_a,
    output logic [DATA_W-1:0] alu_op_b,
    output logic [2:0]        alu_op_code,
    output logic              alu_round_mode,
    output logic              alu_mode_fp,
    output logic              alu_start,
    output logic              alu_ready_in,
    input  logic              alu_ready_out,
    input  logic              alu_valid_out,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [4:0]        alu_flags
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CNT_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_LAST_I[CNT_W-1:0];

    state_t             state_r;
    state_t             state_s;
    logic               prio_r;
    logic               grant_r;
    logic               grant_s;
    logic               req_any_s;
    logic               resp_ready_s;
    logic               timeout_s;
    logic               cap_en_s;
    logic [DATA_W-1:0]  cap_res_s;
    logic [4:0]         cap_flg_s;
    logic               cap_err_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [DATA_W-1:0]  opa_r;
    logic [DATA_W-1:0]  opb_r;
    logic [2:0]         opc_r;
    logic               rm_r;
    logic               fp_r;
    logic [DATA_W-1:0]  res0_r;
    logic [DATA_W-1:0]  res1_r;
    logic [4:0]         flg0_r;
    logic [4:0]         flg1_r;
    logic               err0_r;
    logic               err1_r;

    assign req_any_s    = r0_req_valid | r1_req_valid;
    assign resp_ready_s = grant_r ? r1_resp_ready : r0_resp_ready;
    assign timeout_s    = (TIMEOUT != 0) && (cnt_r == CNT_LAST);

    // Grant selection: a lone requester wins, a tie goes to the priority pointer
    always_comb begin
        grant_s = 1'b0;
        if (r0_req_valid && r1_req_valid) begin
            grant_s = prio_r;
        end else if (r1_req_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (req_any_s)                      state_s = ISSUE; else state_s = IDLE;
            ISSUE:   if (alu_ready_out)                  state_s = WAIT;  else state_s = ISSUE;
            WAIT:    if (alu_valid_out || timeout_s)     state_s = RESP;  else state_s = WAIT;
            RESP:    if (resp_ready_s)                   state_s = IDLE;  else state_s = RESP;
            default:                                     state_s = IDLE;
        endcase
    end

    // Completion capture: a real result beats a simultaneous watchdog expiry
    always_comb begin
        cap_en_s  = (state_r == WAIT) && (alu_valid_out || timeout_s);
        cap_res_s = {DATA_W{1'b0}};
        cap_flg_s = 5'd0;
        cap_err_s = 1'b0;
        if (alu_valid_out) begin
            cap_res_s = alu_result;
            cap_flg_s = alu_flags;
        end else begin
            cap_err_s = 1'b1;
        end
    end

    // State, grant, priority pointer and watchdog counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            prio_r  <= 1'b0;
            grant_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE:    if (req_any_s) grant_r <= grant_s;
                ISSUE:   cnt_r <= {CNT_W{1'b0}};
                WAIT:    cnt_r <= cnt_r + CNT_W'(1);
                RESP:    if (resp_ready_s) prio_r <= ~grant_r;
                default: cnt_r <= {CNT_W{1'b0}};
            endcase
        end
    end

    // Operand latch; these registers drive the ALU directly so they stay stable through WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_r <= {DATA_W{1'b0}};
            opb_r <= {DATA_W{1'b0}};
            opc_r <= 3'd0;
            rm_r  <= 1'b0;
            fp_r  <= 1'b0;
        end else if ((state_r == IDLE) && req_any_s) begin
            opa_r <= grant_s ? r1_op_a       : r0_op_a;
            opb_r <= grant_s ? r1_op_b       : r0_op_b;
            opc_r <= grant_s ? r1_op_code    : r0_op_code;
            rm_r  <= grant_s ? r1_round_mode : r0_round_mode;
            fp_r  <= grant_s ? r1_mode_fp    : r0_mode_fp;
        end
    end

    // Per-requester response registers so each side holds its own last response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res0_r <= {DATA_W{1'b0}};
            flg0_r <= 5'd0;
            err0_r <= 1'b0;
            res1_r <= {DATA_W{1'b0}};
            flg1_r <= 5'd0;
            err1_r <= 1'b0;
        end else if (cap_en_s && grant_r) begin
            res1_r <= cap_res_s;
            flg1_r <= cap_flg_s;
            err1_r <= cap_err_s;
        end else if (cap_en_s) begin
            res0_r <= cap_res_s;
            flg0_r <= cap_flg_s;
            err0_r <= cap_err_s;
        end
    end

    assign r0_req_ready   = (state_r == IDLE) && r0_req_valid && !grant_s;
    assign r1_req_ready   = (state_r == IDLE) && r1_req_valid &&  grant_s;
    assign r0_resp_valid  = (state_r == RESP) && !grant_r;
    assign r1_resp_valid  = (state_r == RESP) &&  grant_r;
    assign r0_result      = res0_r;
    assign r0_flags       = flg0_r;
    assign r0_resp_err    = err0_r;
    assign r1_result      = res1_r;
    assign r1_flags       = flg1_r;
    assign r1_resp_err    = err1_r;
    assign alu_op_a       = opa_r;
    assign alu_op_b       = opb_r;
    assign alu_op_code    = opc_r;
    assign alu_round_mode = rm_r;
    assign alu_mode_fp    = fp_r;
    assign alu_start      = (state_r == ISSUE);
    assign alu_ready_in   = (state_r == WAIT);

endmodule
